// File: rtl/spi_mode_master.sv
// spi_mode_master: SPI master with runtime CPOL/CPHA, bit order, frame length, divider and slave select
module spi_mode_master #(
  parameter int MAX_W = 80,
  parameter int DIV_W = 8,
  parameter int NUM_SS = 4,
  localparam int LW = $clog2(MAX_W + 1),
  localparam int SW = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              spi_clk_i,
  input  logic              spi_rst_i,
  input  logic              spi_start_i,
  input  logic              spi_abort_i,
  input  logic              spi_sendenb_i,
  input  logic              spi_fbo_i,
  input  logic              spi_cpol_i,
  input  logic              spi_cpha_i,
  input  logic [DIV_W-1:0]  clock_divider_i,
  input  logic [LW-1:0]     frame_len_i,
  input  logic [SW-1:0]     ss_sel_i,
  input  logic [MAX_W-1:0]  transmission_data_i,
  input  logic              MISO,
  output logic [NUM_SS-1:0] SS,
  output logic              SCK,
  output logic              MOSI,
  output logic              busy,
  output logic              done,
  output logic              spi_datawe_o,
  output logic [MAX_W-1:0]  received_data_o
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE, WAIT_REL} state_t;
  state_t state_q;
  logic [MAX_W-1:0] sh_q, rx_q, rdata_q, al_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW:0] tc_q;
  logic [DIV_W-1:0] div_q, cnt_q;
  logic [NUM_SS-1:0] ss_q;
  logic cpol_q, cpha_q, fbo_q, send_q, sck_q, mosi_q, done_q, dwe_q;
  logic first_d, nb, cnt_end, last, tog, lead, samp, shout, act;
  assign len_d = (frame_len_i == '0 || frame_len_i > LW'(MAX_W)) ? LW'(MAX_W) : frame_len_i;
  assign al_d = spi_fbo_i ? transmission_data_i : transmission_data_i << (LW'(MAX_W) - len_d);
  assign first_d = spi_fbo_i ? al_d[0] : al_d[MAX_W-1];
  assign nb = fbo_q ? sh_q[0] : sh_q[MAX_W-1];
  assign cnt_end = cnt_q == div_q;
  assign last = tc_q == {len_q, 1'b0};
  assign tog = cnt_end && (state_q == SETUP || (state_q == SHIFT && !last));
  assign lead = sck_q == cpol_q;
  assign samp = tog && (lead ^ cpha_q);
  assign shout = tog && !(lead ^ cpha_q);
  assign act = state_q == SETUP || state_q == SHIFT || state_q == HOLD;
  assign busy = act || state_q == DONE;
  assign SCK = busy ? sck_q : spi_cpol_i;
  assign MOSI = busy & mosi_q;
  assign SS = ss_q;
  assign done = done_q;
  assign spi_datawe_o = dwe_q;
  assign received_data_o = rdata_q;
  // frame sequencer: half-period timing, SCK toggles, MOSI shift-out, MISO capture and completion pulses
  always_ff @(posedge spi_clk_i) begin
    if (spi_rst_i) begin
      state_q <= IDLE;
      ss_q <= '1;
      sck_q <= 1'b0;
      mosi_q <= 1'b0;
      done_q <= 1'b0;
      dwe_q <= 1'b0;
      rdata_q <= '0;
      rx_q <= '0;
      sh_q <= '0;
      cnt_q <= '0;
      tc_q <= '0;
      len_q <= '0;
      div_q <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      fbo_q <= 1'b0;
      send_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dwe_q <= 1'b0;
      cnt_q <= cnt_end ? '0 : cnt_q + 1'b1;
      if (tog) begin
        sck_q <= ~sck_q;
        tc_q <= tc_q + 1'b1;
      end
      if (samp) rx_q <= fbo_q ? {MISO, rx_q[MAX_W-1:1]} : {rx_q[MAX_W-2:0], MISO};
      if (shout) begin
        mosi_q <= send_q & nb;
        sh_q <= fbo_q ? sh_q >> 1 : sh_q << 1;
      end
      if (act && spi_abort_i) begin
        state_q <= IDLE;
        ss_q <= '1;
        sck_q <= cpol_q;
      end else case (state_q)
        IDLE: if (spi_start_i && !spi_abort_i) begin
          state_q <= SETUP;
          cnt_q <= '0;
          tc_q <= '0;
          rx_q <= '0;
          len_q <= len_d;
          div_q <= clock_divider_i;
          cpol_q <= spi_cpol_i;
          cpha_q <= spi_cpha_i;
          fbo_q <= spi_fbo_i;
          send_q <= spi_sendenb_i;
          sck_q <= spi_cpol_i;
          ss_q <= ~(NUM_SS'(1) << ss_sel_i);
          mosi_q <= spi_sendenb_i & first_d & ~spi_cpha_i;
          sh_q <= spi_cpha_i ? al_d : (spi_fbo_i ? al_d >> 1 : al_d << 1);
        end
        SETUP: if (cnt_end) state_q <= SHIFT;
        SHIFT: if (cnt_end && last) state_q <= HOLD;
        HOLD: if (cnt_end) begin
          state_q <= DONE;
          ss_q <= '1;
        end
        DONE: begin
          done_q <= 1'b1;
          dwe_q <= 1'b1;
          rdata_q <= fbo_q ? rx_q >> (LW'(MAX_W) - len_q) : rx_q;
          state_q <= spi_start_i ? WAIT_REL : IDLE;
        end
        default: if (!spi_start_i) state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_mode_master.sv
// tb_spi_mode_master: randomized SPI frames against a protocol-level slave/timing model
module tb_spi_mode_master;
  localparam int MAX_W = 80, DIV_W = 8, NUM_SS = 4, LW = 7, SW = 2;
  logic clk = 1'b0, rst, start, abort, sendenb, fbo, cpol, cpha, miso_r, loopback;
  logic [DIV_W-1:0] div;
  logic [LW-1:0] flen;
  logic [SW-1:0] ss_sel, ss_sel3;
  logic [MAX_W-1:0] txd, rxd, rx3;
  logic [NUM_SS-1:0] ss;
  logic [2:0] ss3;
  logic sck, mosi, busy, done, dwe, miso, sck3, mosi3, busy3, done3, dwe3;
  int total = 0, bad = 0;
  assign miso = loopback ? mosi : miso_r;
  always #5 clk = ~clk;
  spi_mode_master #(.MAX_W(MAX_W), .DIV_W(DIV_W), .NUM_SS(NUM_SS)) dut (
    .spi_clk_i(clk), .spi_rst_i(rst), .spi_start_i(start), .spi_abort_i(abort),
    .spi_sendenb_i(sendenb), .spi_fbo_i(fbo), .spi_cpol_i(cpol), .spi_cpha_i(cpha),
    .clock_divider_i(div), .frame_len_i(flen), .ss_sel_i(ss_sel), .transmission_data_i(txd),
    .MISO(miso), .SS(ss), .SCK(sck), .MOSI(mosi), .busy(busy), .done(done),
    .spi_datawe_o(dwe), .received_data_o(rxd));
  spi_mode_master #(.MAX_W(MAX_W), .DIV_W(DIV_W), .NUM_SS(3)) dut3 (
    .spi_clk_i(clk), .spi_rst_i(rst), .spi_start_i(start), .spi_abort_i(abort),
    .spi_sendenb_i(sendenb), .spi_fbo_i(fbo), .spi_cpol_i(cpol), .spi_cpha_i(cpha),
    .clock_divider_i(div), .frame_len_i(flen), .ss_sel_i(ss_sel3), .transmission_data_i(txd),
    .MISO(miso), .SS(ss3), .SCK(sck3), .MOSI(mosi3), .busy(busy3), .done(done3),
    .spi_datawe_o(dwe3), .received_data_o(rx3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sbit(input logic [MAX_W-1:0] w, input int j, input int l, input logic f);
    return f ? w[j] : w[l-1-j];
  endfunction

  task automatic run_frame(input logic p_cpol, p_cpha, p_fbo, p_send, input logic [DIV_W-1:0] p_div,
      input logic [LW-1:0] p_len, input logic [SW-1:0] p_sel, p_sel3,
      input logic [MAX_W-1:0] p_tx, p_sw, input logic p_loop, p_hold);
    int l, h, edges, si, ci, last_n;
    logic [MAX_W-1:0] mask, exp_rx, exp_cap, scap;
    logic [NUM_SS-1:0] exp_ss;
    logic [2:0] exp_ss3;
    logic prev_sck, lead;
    l = (p_len == 0 || p_len > MAX_W) ? MAX_W : int'(p_len);
    h = int'(p_div) + 1;
    mask = '0;
    for (int i = 0; i < l; i++) mask[i] = 1'b1;
    exp_rx = (p_loop ? (p_send ? p_tx : '0) : p_sw) & mask;
    exp_cap = p_send ? p_tx & mask : '0;
    last_n = (2 * l + 2) * h + 1;
    cpol = p_cpol; cpha = p_cpha; fbo = p_fbo; sendenb = p_send; div = p_div; flen = p_len;
    ss_sel = p_sel; ss_sel3 = p_sel3; txd = p_tx; loopback = p_loop; abort = 1'b0;
    miso_r = p_cpha ? 1'b0 : sbit(p_sw, 0, l, p_fbo);
    start = 1'b1;
    tick();
    txd = MAX_W'({$urandom, $urandom, $urandom}); flen = LW'($urandom); div = DIV_W'($urandom);
    cpol = 1'($urandom); cpha = 1'($urandom); fbo = 1'($urandom); sendenb = 1'($urandom);
    ss_sel = SW'($urandom); ss_sel3 = SW'($urandom);
    start = p_hold;
    edges = 0; si = p_cpha ? 0 : 1; ci = 0; scap = '0; prev_sck = p_cpol;
    for (int n = 0; n <= last_n; n++) begin
      if (n > 0) tick();
      exp_ss = (n < last_n - 1) ? ~(NUM_SS'(1) << p_sel) : '1;
      exp_ss3 = (n < last_n - 1 && p_sel3 < 3) ? ~(3'b001 << p_sel3) : 3'b111;
      total++; if (busy !== (n < last_n)) begin bad++; $display("FAIL busy n=%0d got=%b exp=%b", n, busy, n < last_n); end
      total++; if (busy3 !== (n < last_n)) begin bad++; $display("FAIL busy3 n=%0d got=%b exp=%b", n, busy3, n < last_n); end
      total++; if (ss !== exp_ss) begin bad++; $display("FAIL ss n=%0d got=%b exp=%b", n, ss, exp_ss); end
      total++; if (ss3 !== exp_ss3) begin bad++; $display("FAIL ss3 n=%0d got=%b exp=%b", n, ss3, exp_ss3); end
      total++; if (done !== (n == last_n)) begin bad++; $display("FAIL done n=%0d got=%b exp=%b", n, done, n == last_n); end
      total++; if (dwe !== (n == last_n)) begin bad++; $display("FAIL datawe n=%0d got=%b exp=%b", n, dwe, n == last_n); end
      if (n < last_n) begin
        if (sck !== prev_sck) begin
          edges++;
          lead = sck !== p_cpol;
          total++; if (n != edges * h) begin bad++; $display("FAIL edge_time edge=%0d got=%0d exp=%0d", edges, n, edges * h); end
          if (p_cpha ? !lead : lead) begin
            if (ci < l) scap[p_fbo ? ci : l - 1 - ci] = mosi;
            ci++;
          end else begin
            if (si < l) miso_r = sbit(p_sw, si, l, p_fbo);
            si++;
          end
        end
        prev_sck = sck;
        if (!p_send) begin total++; if (mosi !== 1'b0) begin bad++; $display("FAIL mosi_quiet n=%0d got=%b exp=0", n, mosi); end end
        if (n < h || n >= 2 * l * h) begin
          total++; if (sck !== p_cpol) begin bad++; $display("FAIL sck_idle n=%0d got=%b exp=%b", n, sck, p_cpol); end
        end
      end
    end
    total++; if (edges != 2 * l) begin bad++; $display("FAIL edge_count got=%0d exp=%0d", edges, 2 * l); end
    total++; if (rxd !== exp_rx) begin bad++; $display("FAIL rx got=%h exp=%h", rxd, exp_rx); end
    total++; if (rx3 !== exp_rx) begin bad++; $display("FAIL rx3 got=%h exp=%h", rx3, exp_rx); end
    total++; if (scap !== exp_cap) begin bad++; $display("FAIL mosi_bits got=%h exp=%h", scap, exp_cap); end
    tick();
    total++; if ({done, dwe} !== 2'b00) begin bad++; $display("FAIL pulse_width got=%b exp=00", {done, dwe}); end
    total++; if (rxd !== exp_rx) begin bad++; $display("FAIL rx_hold got=%h exp=%h", rxd, exp_rx); end
    cpol = ~p_cpol;
    #1;
    total++; if ({sck, mosi} !== {~p_cpol, 1'b0}) begin bad++; $display("FAIL idle_lines got=%b exp=%b", {sck, mosi}, {~p_cpol, 1'b0}); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b1; cpol = 1'b0; cpha = 1'b0; fbo = 1'b0; sendenb = 1'b0;
    div = '0; flen = '0; ss_sel = '0; ss_sel3 = '0; txd = '0; miso_r = 1'b0; loopback = 1'b0;
    tick(); tick(); tick();
    total++; if (ss !== 4'hF) begin bad++; $display("FAIL rst_ss got=%b exp=1111", ss); end
    total++; if ({sck, mosi, busy, done, dwe} !== 5'b0) begin bad++; $display("FAIL rst_ctl got=%b exp=00000", {sck, mosi, busy, done, dwe}); end
    total++; if (rxd !== '0) begin bad++; $display("FAIL rst_rx got=%h exp=0", rxd); end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    tick();
  endtask

  task automatic test_mode0_loopback();
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 7'd8, 2'd0, 2'd0, 80'hA5, 80'h0, 1'b1, 1'b0);
  endtask

  task automatic test_modes();
    for (int m = 0; m < 4; m++)
      run_frame(1'(m >> 1), 1'(m), 1'b0, 1'b1, 8'd3, 7'd16, 2'(m), 2'(m),
        MAX_W'({$urandom, $urandom, $urandom}), 80'h3C96, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++)
      run_frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), DIV_W'($urandom_range(0, 3)),
        LW'($urandom_range(0, 90)), SW'($urandom), SW'($urandom),
        MAX_W'({$urandom, $urandom, $urandom}), MAX_W'({$urandom, $urandom, $urandom}), 1'b0, 1'b0);
  endtask

  task automatic test_lsb_recv();
    run_frame(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 7'd0, 2'd2, 2'd2,
      MAX_W'({$urandom, $urandom, $urandom}), MAX_W'({$urandom, $urandom, $urandom}) | 80'h1, 1'b0, 1'b0);
    run_frame(1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 7'd0, 2'd3, 2'd0,
      MAX_W'({$urandom, $urandom, $urandom}), MAX_W'({$urandom, $urandom, $urandom}), 1'b0, 1'b0);
  endtask

  task automatic test_ss3();
    run_frame(1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 7'd12, 2'd3, 2'd3, 80'hABC, 80'h5A5, 1'b0, 1'b0);
    run_frame(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 7'd12, 2'd1, 2'd1, 80'h123, 80'hF0F, 1'b0, 1'b0);
  endtask

  task automatic test_hold();
    int extra = 0, busy_cnt = 0;
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 7'd8, 2'd1, 2'd1, 80'h3D, 80'hC2, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (done || dwe) extra++;
      if (busy) busy_cnt++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL hold_extra_done got=%0d exp=0", extra); end
    total++; if (busy_cnt != 0) begin bad++; $display("FAIL hold_busy got=%0d exp=0", busy_cnt); end
    start = 1'b0;
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_release got=%b exp=0", busy); end
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 7'd8, 2'd1, 2'd1, 80'h6E, 80'h91, 1'b0, 1'b0);
  endtask

  task automatic run_until_edges(input int want);
    int edges = 0, n = 0;
    logic prev;
    prev = sck;
    while (edges < want && n < 400) begin
      tick();
      n++;
      if (sck !== prev) edges++;
      prev = sck;
    end
    total++; if (edges != want) begin bad++; $display("FAIL edge_wait got=%0d exp=%0d", edges, want); end
  endtask

  task automatic test_abort();
    logic [MAX_W-1:0] old;
    int seen;
    start = 1'b1; abort = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_abort got=%b exp=0", busy); end
    start = 1'b0; abort = 1'b0;
    tick();
    old = rxd;
    cpol = 1'b1; cpha = 1'b0; fbo = 1'b0; sendenb = 1'b1; div = 8'd1; flen = 7'd16; ss_sel = 2'd2;
    txd = MAX_W'({$urandom, $urandom, $urandom}); loopback = 1'b0; miso_r = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_until_edges(5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (ss !== 4'hF) begin bad++; $display("FAIL abort_ss got=%b exp=1111", ss); end
    total++; if ({busy, sck} !== 2'b01) begin bad++; $display("FAIL abort_ctl got=%b exp=01", {busy, sck}); end
    seen = 0;
    for (int i = 0; i < 100; i++) begin tick(); if (done || dwe) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_done got=%0d exp=0", seen); end
    total++; if (rxd !== old) begin bad++; $display("FAIL abort_rx got=%h exp=%h", rxd, old); end
    start = 1'b1;
    tick();
    start = 1'b0;
    cpol = 1'b0;
    run_until_edges(7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (ss !== 4'hF) begin bad++; $display("FAIL rstmid_ss got=%b exp=1111", ss); end
    total++; if ({busy, sck, mosi} !== 3'b000) begin bad++; $display("FAIL rstmid_ctl got=%b exp=000", {busy, sck, mosi}); end
    total++; if (rxd !== '0) begin bad++; $display("FAIL rstmid_rx got=%h exp=0", rxd); end
    seen = 0;
    for (int i = 0; i < 100; i++) begin tick(); if (done || dwe) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL rstmid_done got=%0d exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_mode0_loopback();
    test_modes();
    test_random();
    test_lsb_recv();
    test_ss3();
    test_hold();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
